// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache memory arbiter: FSM state encoding and
// requester-select constants.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    BUSY_I = 3'b001,
    BUSY_D = 3'b010,
    HOLD_I = 3'b011,
    HOLD_D = 3'b100
  } arb_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/arb_timeout_cntr.sv
// 8-bit saturating wait counter for the memory arbiter; tc flags the last
// permitted waiting cycle so an owner gets exactly TIMEOUT cycles.
module arb_timeout_cntr
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // count holds cycles already waited, so expiry fires on the TIMEOUT-th one
  assign tc = (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the shared main-memory port between I-cache and D-cache
// controllers. Optional build macro: ARB_ROUND_ROBIN_EN (alternating priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_rd_wrt,
  input  logic              i_lock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_rd_wrt,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_rd_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  arb_state_t state, state_nxt;
  arb_state_t both_pick;
  logic       set_done_i, set_done_d, capture, set_err;
  logic       cnt_clr, cnt_en, tc;

`ifdef ARB_ROUND_ROBIN_EN
  arb_sel_t last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= SEL_D;
    end else if (state_nxt == BUSY_I) begin
      last_owner <= SEL_I;
    end else if (state_nxt == BUSY_D) begin
      last_owner <= SEL_D;
    end
  end

  assign both_pick = (last_owner == SEL_D) ? BUSY_I : BUSY_D;
`else
  assign both_pick = BUSY_D;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    set_done_i = 1'b0;
    set_done_d = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && i_req) begin
          state_nxt = both_pick;
        end else if (d_req) begin
          state_nxt = BUSY_D;
        end else if (i_req) begin
          state_nxt = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_done) begin
          set_done_i = 1'b1;
          capture    = 1'b1;
          state_nxt  = i_lock ? HOLD_I : IDLE;
        end else if (tc) begin
          set_done_i = 1'b1;
          set_err    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_done) begin
          set_done_d = 1'b1;
          capture    = 1'b1;
          state_nxt  = d_lock ? HOLD_D : IDLE;
        end else if (tc) begin
          set_done_d = 1'b1;
          set_err    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      HOLD_I: begin
        if (i_req) begin
          state_nxt = BUSY_I;
        end else if (!i_lock || tc) begin
          state_nxt = IDLE;
        end
      end
      HOLD_D: begin
        if (d_req) begin
          state_nxt = BUSY_D;
        end else if (!d_lock || tc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // every state change restarts the wait budget, including HOLD -> BUSY
  assign cnt_clr = (state_nxt != state) || (state == IDLE);
  assign cnt_en  = (state != IDLE);

  arb_timeout_cntr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (tc)
  );

  assign i_gnt      = (state == BUSY_I) || (state == HOLD_I);
  assign d_gnt      = (state == BUSY_D) || (state == HOLD_D);
  assign mem_enable = (state == BUSY_I) || (state == BUSY_D);

  always_comb begin
    mem_rd_wrt = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (i_gnt) begin
      mem_rd_wrt = i_rd_wrt;
      mem_addr   = i_addr;
      mem_wdata  = i_wdata;
    end else if (d_gnt) begin
      mem_rd_wrt = d_rd_wrt;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      rdata       <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_done <= set_done_i;
      d_done <= set_done_d;
      if (capture) begin
        rdata <= mem_rdata;
      end
      if (set_err) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 255;

  logic          clk, rst;
  logic          i_req, i_rd_wrt, i_lock, i_gnt, i_done;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          d_req, d_rd_wrt, d_lock, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata;
  logic          mem_enable, mem_rd_wrt, mem_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          timeout_err;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_rd_wrt(i_rd_wrt), .i_lock(i_lock), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_rd_wrt(d_rd_wrt), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done),
    .rdata(rdata), .mem_enable(mem_enable), .mem_rd_wrt(mem_rd_wrt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0=none 1=I 2=D; active=transaction in flight
  int          m_owner, m_wait, m_last;
  bit          m_active, m_i_done, m_d_done, m_err;
  logic [DW-1:0] m_rdata;

  function automatic void model_reset();
    m_owner = 0; m_wait = 0; m_last = 2; m_active = 0;
    m_i_done = 0; m_d_done = 0; m_err = 0; m_rdata = '0;
  endfunction

  function automatic void model_done();
    if (m_owner == 1) m_i_done = 1; else m_d_done = 1;
  endfunction

  function automatic void model_edge();
    bit req_o, lock_o;
    req_o  = (m_owner == 1) ? i_req  : d_req;
    lock_o = (m_owner == 1) ? i_lock : d_lock;
    m_i_done = 0;
    m_d_done = 0;
    if (m_owner == 0) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner = (m_last == 2) ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (d_req) m_owner = 2;
      else if (i_req) m_owner = 1;
      if (m_owner != 0) begin
        m_active = 1; m_wait = 0; m_last = m_owner;
      end
    end else if (m_active) begin
      if (mem_done) begin
        model_done();
        m_rdata = mem_rdata;
        m_wait  = 0;
        m_active = 0;
        if (!lock_o) m_owner = 0;
      end else if (m_wait + 1 >= int'(TO)) begin
        model_done();
        m_err = 1; m_owner = 0; m_active = 0;
      end else begin
        m_wait++;
      end
    end else begin
      if (req_o) begin
        m_active = 1; m_wait = 0; m_last = m_owner;
      end else if (!lock_o || (m_wait + 1 >= int'(TO))) begin
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("i_gnt", 64'(i_gnt), 64'(m_owner == 1));
    check("d_gnt", 64'(d_gnt), 64'(m_owner == 2));
    check("gnt_onehot", 64'(i_gnt & d_gnt), 64'd0);
    check("mem_enable", 64'(mem_enable), 64'(m_active));
    check("i_done", 64'(i_done), 64'(m_i_done));
    check("d_done", 64'(d_done), 64'(m_d_done));
    check("rdata", rdata, m_rdata);
    check("timeout_err", 64'(timeout_err), 64'(m_err));
    if (m_active) begin
      check("mem_addr", 64'(mem_addr), 64'((m_owner == 1) ? i_addr : d_addr));
      check("mem_rd_wrt", 64'(mem_rd_wrt), 64'((m_owner == 1) ? i_rd_wrt : d_rd_wrt));
      check("mem_wdata", mem_wdata, (m_owner == 1) ? i_wdata : d_wdata);
    end else if (m_owner == 0) begin
      check("mem_addr_idle", 64'(mem_addr), 64'd0);
      check("mem_wdata_idle", mem_wdata, 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet_inputs();
    i_req = 0; i_rd_wrt = 0; i_lock = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_rd_wrt = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    mem_done = 0; mem_rdata = '0;
  endtask

  initial begin
    int en_cnt;
    int cyc;
    quiet_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
    step();
    rst = 1'b0;
    step();

    // single I read, memory answers 4 cycles after the request
    i_req = 1; i_rd_wrt = 1; i_addr = 16'h0040;
    en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_enable) en_cnt++;
    end
    mem_done = 1; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    step();
    check("t1_enable_cycles", 64'(en_cnt), 64'd4);
    check("t1_i_done", 64'(i_done), 64'd1);
    check("t1_rdata", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_released", 64'(i_gnt), 64'd0);
    mem_done = 0; i_req = 0;
    step();
    check("t1_done_pulse", 64'(i_done), 64'd0);

    // simultaneous requests: D first, I after d_done
    i_req = 1; d_req = 1; i_rd_wrt = 1; d_rd_wrt = 1;
    i_addr = 16'h1111; d_addr = 16'h2222;
    step();
    check("t2_d_first", 64'({d_gnt, i_gnt}), 64'b10);
    step();
    mem_done = 1; mem_rdata = 64'hDDDD_0000_DDDD_0001;
    step();
    mem_done = 0; d_req = 0;
    step();
    check("t2_i_after", 64'({d_gnt, i_gnt}), 64'b01);
    mem_done = 1; mem_rdata = 64'h1111_2222_3333_4444;
    step();
    mem_done = 0; i_req = 0;
    step();

    // locked D miss then writeback, I requesting throughout
    d_req = 1; d_lock = 1; d_rd_wrt = 1; d_addr = 16'h0300; i_req = 1;
    step();
    step();
    mem_done = 1; mem_rdata = 64'hCAFE_F00D_0000_0001;
    step();
    mem_done = 0; d_req = 0;
    step();
    check("t3_hold_gnt", 64'({d_gnt, i_gnt, mem_enable}), 64'b100);
    d_req = 1; d_lock = 0; d_rd_wrt = 0; d_wdata = 64'h1234;
    step();
    check("t3_wb_write", 64'(mem_rd_wrt), 64'd0);
    check("t3_wb_data", mem_wdata, 64'h1234);
    step();
    mem_done = 1;
    step();
    mem_done = 0; d_req = 0;
    step();
    check("t3_i_after_wb", 64'({d_gnt, i_gnt}), 64'b01);
    mem_done = 1;
    step();
    mem_done = 0; i_req = 0;
    step();

    // timeout: I granted, memory never answers
    i_req = 1; i_rd_wrt = 1; i_addr = 16'h0BAD;
    step();
    cyc = 0;
    while (!timeout_err && cyc < 400) begin
      step();
      cyc++;
    end
    check("t4_timeout_cycles", 64'(cyc), 64'(TO));
    check("t4_i_done", 64'(i_done), 64'd1);
    check("t4_idle", 64'(i_gnt), 64'd0);
    i_req = 0;
    for (int k = 0; k < 5; k++) step();
    check("t4_sticky", 64'(timeout_err), 64'd1);

    // reset during BUSY_D, late mem_done must be ignored
    d_req = 1; d_rd_wrt = 1; d_addr = 16'h0777;
    step();
    step();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("t5_no_gnt", 64'({d_gnt, mem_enable, timeout_err}), 64'b000);
    d_req = 0;
    step();
    rst = 1'b0;
    mem_done = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("t5_no_done", 64'(d_done), 64'd0);
    mem_done = 0;
    step();

    // random traffic against the model
    for (int k = 0; k < 800; k++) begin
      i_req     = ($urandom_range(0, 3) != 0);
      d_req     = ($urandom_range(0, 2) == 0);
      i_lock    = ($urandom_range(0, 3) == 0);
      d_lock    = ($urandom_range(0, 2) == 0);
      i_rd_wrt  = 1'($urandom);
      d_rd_wrt  = 1'($urandom);
      i_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      i_wdata   = {$urandom, $urandom};
      d_wdata   = {$urandom, $urandom};
      mem_done  = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
